// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM state encoding and the
// width helper used to size the PC-repeat counter.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_TMO  = 2'd3
  } state_t;

  function automatic int unsigned same_cnt_w(input int unsigned halt_repeat);
    return $clog2(halt_repeat + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of
// wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller for the pipelined MIPS core: sequences the core reset,
// counts cycles and retired instructions, and ends the run on a PC
// self-loop (halt) or when the cycle budget is used up (timeout).
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 100000,
  parameter int unsigned HALT_REPEAT  = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PC_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_en,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             cpu_reset,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             done,
  output logic             timeout,
  output logic [1:0]       state
);

  localparam int unsigned SW = same_cnt_w(HALT_REPEAT);
  localparam int unsigned RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t           st, st_nxt;
  logic [RW-1:0]    rst_cnt;
  logic [SW-1:0]    same_cnt, same_upd;
  logic [PC_W-1:0]  last_pc;
  logic             have_pc;
  logic             running, cyc_inc, ins_inc, in_rst;
  logic             pc_match, halt_hit, tmo_hit;
  logic [CNT_W-1:0] cycle_upd;
  logic             cpu_reset_nxt, done_nxt, timeout_nxt;

  assign running = (st == ST_RUN);
  assign in_rst  = (st == ST_RST);
  assign cyc_inc = running && run_en;
  assign ins_inc = running && pc_valid;
  assign state   = st;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (in_rst),
    .inc   (cyc_inc),
    .q     (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (in_rst),
    .inc   (ins_inc),
    .q     (instr_cnt)
  );

  // Halt/timeout are judged on the post-edge counter values, so they are
  // recomputed here instead of waiting a cycle for the registers.
  always_comb begin
    pc_match  = pc_valid && have_pc && (pc == last_pc);
    same_upd  = pc_match ? (same_cnt + SW'(1)) : SW'(1);
    halt_hit  = running && pc_match && (same_upd == SW'(HALT_REPEAT));
    cycle_upd = (cycle_cnt == '1) ? cycle_cnt : (cycle_cnt + CNT_W'(1));
    tmo_hit   = cyc_inc && (cycle_upd == CNT_W'(MAX_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_RST;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      st        <= st_nxt;
      cpu_reset <= cpu_reset_nxt;
      done      <= done_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      ST_RST:  if (rst_cnt == RW'(RESET_CYCLES - 1)) st_nxt = ST_RUN;
      ST_RUN: begin
        if (halt_hit)     st_nxt = ST_HALT;
        else if (tmo_hit) st_nxt = ST_TMO;
      end
      default: st_nxt = st;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    cpu_reset_nxt = (st_nxt == ST_RST);
    done_nxt      = (st_nxt == ST_HALT) || (st_nxt == ST_TMO);
    timeout_nxt   = (st_nxt == ST_TMO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt  <= '0;
      same_cnt <= '0;
      have_pc  <= 1'b0;
      last_pc  <= '0;
    end else begin
      if (in_rst) begin
        rst_cnt <= rst_cnt + RW'(1);
      end
      if (ins_inc) begin
        last_pc  <= pc;
        have_pc  <= 1'b1;
        same_cnt <= same_upd;
      end
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: a phase/history reference model predicts
// outputs per cycle, a monitor compares them after each rising edge.
module tb_run_ctrl;

  localparam int unsigned RC   = 2;
  localparam int unsigned HR   = 4;
  localparam int unsigned MC   = 20;
  localparam int unsigned CMAX = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1, run_en = 1'b0, pc_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        cpu_reset, done, timeout;
  logic [31:0] cycle_cnt, instr_cnt;
  logic [1:0]  state;

  logic        s_reset = 1'b1, s_run_en = 1'b0, s_pc_valid = 1'b0;
  logic [31:0] s_pc = '0;
  logic        s_cpu_reset, s_done, s_timeout;
  logic [3:0]  s_cycle_cnt, s_instr_cnt;
  logic [1:0]  s_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_ctrl #(.RESET_CYCLES(RC), .MAX_CYCLES(MC), .HALT_REPEAT(HR),
             .CNT_W(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(cpu_reset), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
    .done(done), .timeout(timeout), .state(state)
  );

  run_ctrl #(.RESET_CYCLES(RC), .MAX_CYCLES(15), .HALT_REPEAT(HR),
             .CNT_W(4), .PC_W(32)) dut_sat (
    .clk(clk), .reset(s_reset), .run_en(s_run_en), .pc(s_pc), .pc_valid(s_pc_valid),
    .cpu_reset(s_cpu_reset), .cycle_cnt(s_cycle_cnt), .instr_cnt(s_instr_cnt),
    .done(s_done), .timeout(s_timeout), .state(s_state)
  );

  typedef struct {
    logic        cpu_reset;
    int unsigned cyc;
    int unsigned ins;
    logic        done;
    logic        tmo;
    int unsigned st;
  } exp_t;

  exp_t sb[$];

  // Reference model: phase 0..3 = RST/RUN/HALT/TMO.
  int unsigned m_phase = 0, m_rcnt = 0, m_cyc = 0, m_ins = 0;
  bit          m_done = 0, m_tmo = 0;
  logic [31:0] hist[$];

  function automatic void chk(input string name, input longint unsigned act,
                              input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(input bit r, input bit en, input bit v, input logic [31:0] p);
    bit   h, t;
    exp_t e;
    @(negedge clk);
    reset = r; run_en = en; pc_valid = v; pc = p;
    if (r) begin
      m_phase = 0; m_rcnt = 0; m_cyc = 0; m_ins = 0;
      m_done = 0; m_tmo = 0; hist.delete();
    end else if (m_phase == 0) begin
      m_rcnt++;
      if (m_rcnt == RC) m_phase = 1;
    end else if (m_phase == 1) begin
      if (en && m_cyc != CMAX) m_cyc++;
      if (v && m_ins != CMAX) m_ins++;
      h = 0;
      if (v) begin
        hist.push_back(p);
        if (hist.size() > HR) void'(hist.pop_front());
        h = (hist.size() == HR);
        foreach (hist[i]) if (hist[i] != p) h = 0;
      end
      t = en && (m_cyc == MC);
      if (h) begin
        m_phase = 2; m_done = 1;
      end else if (t) begin
        m_phase = 3; m_done = 1; m_tmo = 1;
      end
    end
    e.cpu_reset = (m_phase == 0);
    e.cyc = m_cyc; e.ins = m_ins; e.done = m_done; e.tmo = m_tmo; e.st = m_phase;
    sb.push_back(e);
  endtask

  task automatic rst_run(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 1, 32'h3008);
    for (int i = 0; i < RC; i++) step(0, 1, 1, 32'h3008);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cpu_reset", cpu_reset, e.cpu_reset);
        chk("cycle_cnt", cycle_cnt, e.cyc);
        chk("instr_cnt", instr_cnt, e.ins);
        chk("done", done, e.done);
        chk("timeout", timeout, e.tmo);
        chk("state", state, e.st);
      end
    end
  end

  initial begin : stim
    bit          r, en, v;
    logic [31:0] p;

    rst_run(3);
    step(0, 1, 1, 32'h3000); step(0, 1, 1, 32'h3004);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 32'h3008);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h3100 + 4 * i);

    rst_run(1);
    step(0, 1, 1, 32'h3008); step(0, 1, 0, 32'h3008); step(0, 1, 1, 32'h3008);
    step(0, 1, 0, 32'h3008); step(0, 1, 0, 32'h3008);
    step(0, 1, 1, 32'h3008); step(0, 1, 1, 32'h3008);
    step(0, 1, 1, 32'h3008);

    rst_run(1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h3008);
    step(0, 1, 1, 32'h300C);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h3008);

    rst_run(1);
    for (int i = 0; i < 23; i++) step(0, 1, 1, 32'h3000 + 4 * i);
    rst_run(1);
    for (int i = 0; i < 44; i++) step(0, (i % 2) == 0, 1, 32'h3000 + 4 * i);

    rst_run(1);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 32'h1000 + 4 * i);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 32'h3010);

    rst_run(2);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 32'h2000 + 4 * i);
    step(1, 1, 1, 32'h2100);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 32'h2200 + 4 * i);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 149) == 0) || (m_phase >= 2 && $urandom_range(0, 5) == 0);
      en = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 3) != 0);
      p  = 32'h3000 + 4 * $urandom_range(0, 3);
      step(r, en, v, p);
    end

    @(negedge clk);
    s_reset = 1'b0; s_pc_valid = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      s_pc = 32'h4000 + 4 * e;
      @(negedge clk);
      chk("sat_instr_cnt", s_instr_cnt, (e <= 2) ? 0 : ((e - 2 > 15) ? 15 : e - 2));
    end
    chk("sat_state", s_state, 1);
    chk("sat_cycle_cnt", s_cycle_cnt, 0);
    chk("sat_done", s_done, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
